univ_shift_reg_n: RTL

- Parametrised successor to the 4-bit universal shift register (194-style) in the logic-family library.
- Adds width generalisation, rotate, arithmetic and clear modes, and a multi-step burst shift with BUSY/DONE handshake.
- Sits beside the mux/gate blocks in the top-level glue and drives parallel Q outputs plus serial taps.

---
 rtl/univ_shift_reg_n.sv | 119 +++++++++++
 1 files changed

// File: rtl/univ_shift_reg_n.sv
// Parametrised 194-style universal shift register with rotate, arithmetic and
// clear modes, plus a multi-step burst shift with a BUSY/DONE handshake.

module usr_bit_cell (
  input  logic [2:0] op,
  input  logic       q_cur,
  input  logic       r_in,
  input  logic       l_in,
  input  logic       d_in,
  output logic       q_nxt
);
  // r_in: value arriving from the Q[0] side, l_in: from the Q[W-1] side
  always_comb begin
    q_nxt = q_cur;
    case (op)
      3'b001, 3'b100:         q_nxt = r_in;
      3'b010, 3'b101, 3'b110: q_nxt = l_in;
      3'b011:                 q_nxt = d_in;
      3'b111:                 q_nxt = 1'b0;
      default:                q_nxt = q_cur;
    endcase
  end
endmodule

module univ_shift_reg_n #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             CP,
  input  logic             MR,
  input  logic             CE,
  input  logic [2:0]       S,
  input  logic [WIDTH-1:0] D,
  input  logic             DSR,
  input  logic             DSL,
  input  logic             START,
  input  logic [AMT_W-1:0] AMT,
  output logic [WIDTH-1:0] Q,
  output logic             SO_R,
  output logic             SO_L,
  output logic             BUSY,
  output logic             DONE
);
  logic [WIDTH-1:0] q_r, q_nxt;
  logic [AMT_W-1:0] cnt;
  logic [2:0]       op_lat, op_eff;
  logic             busy, done, is_shift;

  always_comb begin
    is_shift = 1'b0;
    case (S)
      3'b001, 3'b010, 3'b100, 3'b101, 3'b110: is_shift = 1'b1;
      default:                                is_shift = 1'b0;
    endcase
  end

  // During a burst the latched op drives the datapath; S is ignored
  assign op_eff = busy ? op_lat : S;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic r_in, l_in;
    if (i == 0) begin : g_r_edge
      assign r_in = (op_eff == 3'b100) ? q_r[WIDTH-1] : DSR;
    end else begin : g_r_mid
      assign r_in = q_r[i-1];
    end
    if (i == WIDTH-1) begin : g_l_edge
      assign l_in = (op_eff == 3'b101) ? q_r[0] :
                    (op_eff == 3'b110) ? q_r[WIDTH-1] : DSL;
    end else begin : g_l_mid
      assign l_in = q_r[i+1];
    end
    usr_bit_cell u_cell (
      .op   (op_eff),
      .q_cur(q_r[i]),
      .r_in (r_in),
      .l_in (l_in),
      .d_in (D[i]),
      .q_nxt(q_nxt[i])
    );
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      q_r    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      op_lat <= 3'b000;
    end else begin
      done <= 1'b0;
      if (busy) begin
        q_r <= q_nxt;
        cnt <= cnt - 1'b1;
        if (cnt == AMT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (START) begin
        // Non-shift modes and zero-length bursts complete immediately
        if (is_shift && AMT != '0) begin
          op_lat <= S;
          cnt    <= AMT;
          busy   <= 1'b1;
        end else begin
          done <= 1'b1;
        end
      end else if (CE) begin
        q_r <= q_nxt;
      end
    end
  end

  assign Q    = q_r;
  assign SO_R = q_r[WIDTH-1];
  assign SO_L = q_r[0];
  assign BUSY = busy;
  assign DONE = done;
endmodule
